pb_input_conditioner: RTL and testbench

- Parametrised push-button front end between breakout-board input pins and the core.
- Replaces raw `pb` feeding with per-channel synchronisation, debounce, edge pulses and a priority-encoded key code.
- Channel count, sync depth and debounce time are all configurable.
- Sits directly under the chip wrapper; the core consumes only conditioned outputs.

---
 rtl/pb_input_conditioner_pkg.sv | 20 ++
 rtl/pb_input_conditioner_if.sv | 26 ++
 rtl/pb_input_conditioner_debounce_ch.sv | 122 ++++++++++++
 rtl/pb_input_conditioner.sv | 70 +++++++
 tb/tb_pb_input_conditioner.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pb_input_conditioner_pkg.sv
// Shared constants, counter-width helper and per-channel state encoding for the
// push-button conditioner.
package pb_pkg;

    localparam int PB_MAX_CH   = 32;
    localparam int PB_SYNC_MIN = 2;

    // Bits needed for a counter that must hold values 0..max_count.
    function automatic int pb_cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CNT_UP    = 2'd1,
        IDLE_HIGH = 2'd2,
        CNT_DN    = 2'd3
    } pb_state_e;

endpackage

// File: rtl/pb_input_conditioner_if.sv
// Button pins in, conditioned level/edge/key-code out; the master side drives
// the enable and pins, the slave side is the conditioner.
interface pb_input_conditioner_if #(
    parameter int N_PB = 15
);
    localparam int CODE_W = $clog2(N_PB + 1);

    logic              en;
    logic [N_PB-1:0]   pb_raw;
    logic [N_PB-1:0]   pb_level;
    logic [N_PB-1:0]   pb_rise;
    logic [N_PB-1:0]   pb_fall;
    logic [CODE_W-1:0] pb_code;
    logic              pb_valid;

    modport master (
        output en, pb_raw,
        input  pb_level, pb_rise, pb_fall, pb_code, pb_valid
    );

    modport slave (
        input  en, pb_raw,
        output pb_level, pb_rise, pb_fall, pb_code, pb_valid
    );

endinterface

// File: rtl/pb_input_conditioner_debounce_ch.sv
// One button channel: synchroniser, debounce counter, registered edge pulses and
// PB_AUTOREPEAT_EN hold-repeat; level settles SYNC_STAGES+DEBOUNCE_CYCLES edges after a step, no backpressure.
module pb_debounce_ch
    import pb_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
`ifdef PB_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_RATE     = 100000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic pb_raw,
    output logic pb_level,
    output logic pb_rise,
    output logic pb_fall
);

    localparam int            CW       = pb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    pb_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_bit;
    logic                   level;
    logic                   edge_rise, edge_fall;
    logic                   rpt_pulse;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], pb_raw};
    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign level    = (state_q == IDLE_HIGH) || (state_q == CNT_DN);

    // Any cycle where the input agrees with the level (or the block is disabled)
    // throws away the partial count, so glitches never accumulate.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_rise = 1'b0;
        edge_fall = 1'b0;
        if (!en || (sync_bit == level)) begin
            cnt_d   = '0;
            state_d = level ? IDLE_HIGH : IDLE_LOW;
        end else if (cnt_q >= CNT_LAST) begin
            cnt_d     = '0;
            state_d   = level ? IDLE_LOW : IDLE_HIGH;
            edge_rise = ~level;
            edge_fall = level;
        end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = level ? CNT_DN : CNT_UP;
        end
    end

`ifdef PB_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW      = pb_cnt_width(REP_MAX);

    logic [HW-1:0] hold_q, hold_d, hold_lim;
    logic          rep_q, rep_d;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE; reload keeps it bounded.
    always_comb begin
        hold_d    = hold_q;
        rep_d     = rep_q;
        rpt_pulse = 1'b0;
        hold_lim  = rep_q ? HW'(REPEAT_RATE - 1) : HW'(REPEAT_DELAY - 1);
        if (!en || !level || edge_fall) begin
            hold_d = '0;
            rep_d  = 1'b0;
        end else if (hold_q >= hold_lim) begin
            hold_d    = '0;
            rep_d     = 1'b1;
            rpt_pulse = 1'b1;
        end else begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`else
    assign rpt_pulse = 1'b0;
`endif

    assign rise_d = edge_rise | rpt_pulse;
    assign fall_d = edge_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign pb_level = level;
    assign pb_rise  = rise_q & en;
    assign pb_fall  = fall_q & en;

endmodule

// File: rtl/pb_input_conditioner.sv
// Push-button front end: N_PB debounced channels plus lowest-index key encoder;
// code/valid share the rise-pulse cycle, no backpressure; PB_AUTOREPEAT_EN adds hold-repeat.
module pb_input_conditioner
    import pb_pkg::*;
#(
    parameter int N_PB            = 15,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_RATE     = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    pb_input_conditioner_if.slave   pb
);

    localparam int CODE_W = $clog2(N_PB + 1);

    if (N_PB < 1 || N_PB > PB_MAX_CH) begin : g_bad_n_pb
        $error("N_PB out of range");
    end
    if (SYNC_STAGES < PB_SYNC_MIN) begin : g_bad_sync
        $error("SYNC_STAGES too small");
    end
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cnt
        $error("cycle counts must be at least 1");
    end

    logic [N_PB-1:0]   level_v;
    logic [N_PB-1:0]   rise_v;
    logic [N_PB-1:0]   fall_v;
    logic [CODE_W-1:0] code_v;

    for (genvar g = 0; g < N_PB; g++) begin : g_ch
        pb_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef PB_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
`endif
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (pb.en),
            .pb_raw   (pb.pb_raw[g]),
            .pb_level (level_v[g]),
            .pb_rise  (rise_v[g]),
            .pb_fall  (fall_v[g])
        );
    end

    // Scan from the top down so the lowest rising index is the last to write.
    always_comb begin
        code_v = '0;
        for (int i = N_PB - 1; i >= 0; i--) begin
            if (rise_v[i]) begin
                code_v = CODE_W'(i + 1);
            end
        end
    end

    assign pb.pb_level = level_v;
    assign pb.pb_rise  = rise_v;
    assign pb.pb_fall  = fall_v;
    assign pb.pb_code  = code_v;
    assign pb.pb_valid = |rise_v;

endmodule

// File: tb/tb_pb_input_conditioner.sv
// Directed and random stimulus for pb_input_conditioner, checked against a
// cycle-level behavioural model of the debounce/edge/key-code rules.
module tb_pb_input_conditioner;

    localparam int N    = 15;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RR   = 8;
    localparam int CW   = $clog2(N + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pb_input_conditioner_if #(.N_PB(N)) bus();

    pb_input_conditioner #(
        .N_PB            (N),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .pb    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: delayed input copy, run-length of disagreement, level.
    logic [N-1:0] m_pipe [SYNC];
    logic [N-1:0] m_level, m_rise, m_fall, m_sync;
    logic         m_was;
    int           streak [N];
`ifdef PB_AUTOREPEAT_EN
    int           held   [N];
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC; s++) m_pipe[s] = '0;
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
            for (int i = 0; i < N; i++) begin
                streak[i] = 0;
`ifdef PB_AUTOREPEAT_EN
                held[i] = 0;
`endif
            end
        end else begin
            m_sync = m_pipe[SYNC-1];
            for (int s = SYNC - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
            m_pipe[0] = bus.pb_raw;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                m_was = m_level[i];
                if (!bus.en) begin
                    streak[i] = 0;
`ifdef PB_AUTOREPEAT_EN
                    held[i] = 0;
`endif
                end else begin
                    if (m_sync[i] == m_level[i]) begin
                        streak[i] = 0;
                    end else begin
                        streak[i]++;
                        if (streak[i] == DEB) begin
                            streak[i]  = 0;
                            m_level[i] = ~m_was;
                            if (m_was) m_fall[i] = 1'b1;
                            else       m_rise[i] = 1'b1;
                        end
                    end
`ifdef PB_AUTOREPEAT_EN
                    if (m_was && !m_fall[i]) begin
                        held[i]++;
                        if (held[i] == RD || (held[i] > RD && (held[i] - RD) % RR == 0))
                            m_rise[i] = 1'b1;
                    end else begin
                        held[i] = 0;
                    end
`endif
                end
            end
        end
    end

    function automatic logic [CW-1:0] first_code(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return CW'(i + 1);
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] er, ef;
        er = m_rise & {N{bus.en}};
        ef = m_fall & {N{bus.en}};
        chk({tag, ".level"}, 32'(bus.pb_level), 32'(m_level));
        chk({tag, ".rise"},  32'(bus.pb_rise),  32'(er));
        chk({tag, ".fall"},  32'(bus.pb_fall),  32'(ef));
        chk({tag, ".code"},  32'(bus.pb_code),  32'(first_code(er)));
        chk({tag, ".valid"}, 32'(bus.pb_valid), 32'(|er));
    endtask

    task automatic cyc(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_model(tag);
        end
    endtask

    initial begin
        int n9;
        int exp9;
        rst        = 1'b0;
        bus.en     = 1'b0;
        bus.pb_raw = '0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_level", 32'(bus.pb_level), 0);
        chk("async_rst_rise",  32'(bus.pb_rise),  0);
        chk("async_rst_code",  32'(bus.pb_code),  0);
        chk("async_rst_valid", 32'(bus.pb_valid), 0);
        repeat (2) @(negedge clk);
        check_model("reset");
        rst    = 1'b0;
        bus.en = 1'b1;
        cyc(3, "idle");

        // Clean step on channel 3
        bus.pb_raw[3] = 1'b1;
        cyc(5, "t1");
        chk("t1_level_early", 32'(bus.pb_level[3]), 0);
        cyc(1, "t1");
        chk("t1_level", 32'(bus.pb_level), 32'h0008);
        chk("t1_rise",  32'(bus.pb_rise),  32'h0008);
        chk("t1_code",  32'(bus.pb_code),  4);
        chk("t1_valid", 32'(bus.pb_valid), 1);
        cyc(1, "t1");
        chk("t1_rise_end",  32'(bus.pb_rise),  0);
        chk("t1_valid_end", 32'(bus.pb_valid), 0);
        bus.pb_raw[3] = 1'b0;
        cyc(8, "t1_rel");

        // Three-cycle glitch on channel 0
        bus.pb_raw[0] = 1'b1;
        cyc(3, "t2");
        bus.pb_raw[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1, "t2");
            chk("t2_level", 32'(bus.pb_level), 0);
            chk("t2_rise",  32'(bus.pb_rise),  0);
            chk("t2_fall",  32'(bus.pb_fall),  0);
        end

        // Simultaneous rises on 5 and 2
        bus.pb_raw[5] = 1'b1;
        bus.pb_raw[2] = 1'b1;
        cyc(5, "t3");
        chk("t3_rise_early", 32'(bus.pb_rise), 0);
        cyc(1, "t3");
        chk("t3_rise",  32'(bus.pb_rise),  32'h0024);
        chk("t3_code",  32'(bus.pb_code),  3);
        chk("t3_valid", 32'(bus.pb_valid), 1);
        bus.pb_raw = '0;
        cyc(8, "t3_rel");

        // Clean release on channel 7
        bus.pb_raw[7] = 1'b1;
        cyc(10, "t4");
        bus.pb_raw[7] = 1'b0;
        cyc(5, "t4");
        chk("t4_fall_early", 32'(bus.pb_fall), 0);
        cyc(1, "t4");
        chk("t4_fall",  32'(bus.pb_fall),  32'h0080);
        chk("t4_valid", 32'(bus.pb_valid), 0);
        chk("t4_level", 32'(bus.pb_level), 0);
        cyc(1, "t4");
        chk("t4_fall_end", 32'(bus.pb_fall), 0);

        // Rise on channel 1 while disabled
        bus.en        = 1'b0;
        bus.pb_raw[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc(1, "t5");
            chk("t5_rise_dis",  32'(bus.pb_rise),  0);
            chk("t5_valid_dis", 32'(bus.pb_valid), 0);
            chk("t5_level_dis", 32'(bus.pb_level), 0);
        end
        bus.en = 1'b1;
        cyc(3, "t5");
        chk("t5_rise_early", 32'(bus.pb_rise), 0);
        cyc(1, "t5");
        chk("t5_rise", 32'(bus.pb_rise), 32'h0002);
        chk("t5_code", 32'(bus.pb_code), 2);
        bus.pb_raw[1] = 1'b0;
        cyc(8, "t5_rel");

        // Long hold on channel 9
        n9 = 0;
        bus.pb_raw[9] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            cyc(1, "t6");
            if (bus.pb_rise[9]) n9++;
        end
        bus.pb_raw[9] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1, "t6");
            if (bus.pb_rise[9]) n9++;
        end
`ifdef PB_AUTOREPEAT_EN
        exp9 = 6;
`else
        exp9 = 1;
`endif
        chk("t6_rise_count", 32'(n9), 32'(exp9));
        chk("t6_level", 32'(bus.pb_level), 0);

        // Random pin activity with occasional enable drops
        for (int k = 0; k < 400; k++) begin
            cyc(1, "rand");
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) bus.pb_raw[i] = ~bus.pb_raw[i];
            if ($urandom_range(39) == 0) bus.en = ~bus.en;
        end
        bus.en     = 1'b1;
        bus.pb_raw = '0;
        cyc(12, "rand_rel");

        // Reset while one channel pulses and another is mid-count
        bus.pb_raw[4] = 1'b1;
        cyc(3, "t8");
        bus.pb_raw[6] = 1'b1;
        cyc(3, "t8");
        chk("t8_pre_rise", 32'(bus.pb_rise), 32'h0010);
        #2 rst = 1'b1;
        #1;
        chk("t8_rst_level", 32'(bus.pb_level), 0);
        chk("t8_rst_rise",  32'(bus.pb_rise),  0);
        chk("t8_rst_fall",  32'(bus.pb_fall),  0);
        chk("t8_rst_code",  32'(bus.pb_code),  0);
        chk("t8_rst_valid", 32'(bus.pb_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(5, "t8_post");
        chk("t8_post_early", 32'(bus.pb_level), 0);
        cyc(1, "t8_post");
        chk("t8_post_level", 32'(bus.pb_level), 32'h0050);
        chk("t8_post_rise",  32'(bus.pb_rise),  32'h0050);
        chk("t8_post_code",  32'(bus.pb_code),  5);
        cyc(4, "t8_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
